// File: rtl/alu_control_sequencer_if.sv
// Control bundle between the ALU instruction sequencer and the datapath.
// The master side is the sequencer; the slave side is the datapath or the bench.
interface alu_control_sequencer_if #(
  parameter int NREGS = 16
);
  logic             start;
  logic             w_mem_ready;
  logic [31:0]      w_IR;

  logic             s_PC, s_Zlow, s_Zhigh, s_MDR;
  logic [NREGS-1:0] s_R;
  logic [NREGS-1:0] e_R;
  logic             e_MAR, e_Z, e_PC, e_MDR, e_IR, e_Y, e_HI, e_LO, e_alu;
  logic             w_IncPC, w_read;
  logic [5:0]       opcode;
  logic             busy, done, illegal;

  modport master (
    input  start, w_mem_ready, w_IR,
    output s_PC, s_Zlow, s_Zhigh, s_MDR, s_R, e_R,
           e_MAR, e_Z, e_PC, e_MDR, e_IR, e_Y, e_HI, e_LO, e_alu,
           w_IncPC, w_read, opcode, busy, done, illegal
  );

  modport slave (
    output start, w_mem_ready, w_IR,
    input  s_PC, s_Zlow, s_Zhigh, s_MDR, s_R, e_R,
           e_MAR, e_Z, e_PC, e_MDR, e_IR, e_Y, e_HI, e_LO, e_alu,
           w_IncPC, w_read, opcode, busy, done, illegal
  );
endinterface

// File: rtl/alu_control_sequencer.sv
// T-state sequencer for register-to-register ALU instructions: fetch, decode,
// then steer operands through Y, the ALU and Z into Ra or LO/HI.
module alu_control_sequencer #(
  parameter int NREGS = 16
) (
  input  logic                    w_clock,
  input  logic                    w_clear,
  alu_control_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_e;
  typedef enum logic [1:0] {CLS_ILLEGAL, CLS_UNARY, CLS_BINARY, CLS_MULDIV} op_class_e;

  function automatic op_class_e classify(input logic [4:0] op);
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3,
      5'd7, 5'd8, 5'd9, 5'd10, 5'd11: return CLS_BINARY;
      5'd5, 5'd6:                     return CLS_MULDIV;
      5'd4, 5'd12:                    return CLS_UNARY;
      default:                        return CLS_ILLEGAL;
    endcase
  endfunction

  function automatic logic [NREGS-1:0] onehot(input logic [3:0] idx);
    logic [NREGS-1:0] one;
    one = NREGS'(1);
    return one << idx;
  endfunction

  state_e     state;
  op_class_e  cls_q;
  logic [3:0] ra_q, rc_q;
  logic [5:0] opcode_q;
  logic       done_q, illegal_q;

  op_class_e  ir_cls;
  logic       unused_ir;

  assign ir_cls    = classify(bus.w_IR[31:27]);
  assign unused_ir = ^bus.w_IR[14:0];

  // NOTE: all state below uses non-blocking assignments so every register
  // sees the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge w_clock or negedge w_clear) begin
    if (!w_clear) begin
      state     <= IDLE;
      cls_q     <= CLS_ILLEGAL;
      ra_q      <= '0;
      rc_q      <= '0;
      opcode_q  <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) state <= T0;
        T0:   state <= T1;
        T1:   if (bus.w_mem_ready) state <= T2;
        T2:   state <= T3;
        T3: begin
          ra_q  <= bus.w_IR[26:23];
          rc_q  <= bus.w_IR[18:15];
          cls_q <= ir_cls;
          if (ir_cls == CLS_ILLEGAL) begin
            state     <= IDLE;
            done_q    <= 1'b1;
            illegal_q <= 1'b1;
          end else begin
            opcode_q <= {1'b0, bus.w_IR[31:27]};
            state    <= T4;
          end
        end
        T4: begin
          if (cls_q == CLS_UNARY) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end else begin
            state <= T5;
          end
        end
        T5: begin
          if (cls_q == CLS_MULDIV) begin
            state <= T6;
          end else begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        T6: begin
          state  <= IDLE;
          done_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode from the state and latched fields; T3 reads the fresh IR
  // directly because the fields are only captured on the edge leaving T3.
  always_comb begin
    // NOTE: every output gets a default first so no case path infers a latch.
    bus.s_PC    = 1'b0;
    bus.s_Zlow  = 1'b0;
    bus.s_Zhigh = 1'b0;
    bus.s_MDR   = 1'b0;
    bus.s_R     = '0;
    bus.e_R     = '0;
    bus.e_MAR   = 1'b0;
    bus.e_Z     = 1'b0;
    bus.e_PC    = 1'b0;
    bus.e_MDR   = 1'b0;
    bus.e_IR    = 1'b0;
    bus.e_Y     = 1'b0;
    bus.e_HI    = 1'b0;
    bus.e_LO    = 1'b0;
    bus.e_alu   = 1'b0;
    bus.w_IncPC = 1'b0;
    bus.w_read  = 1'b0;
    bus.opcode  = opcode_q;
    case (state)
      T0: begin
        bus.s_PC    = 1'b1;
        bus.e_MAR   = 1'b1;
        bus.w_IncPC = 1'b1;
        bus.e_Z     = 1'b1;
      end
      T1: begin
        bus.s_Zlow  = 1'b1;
        bus.e_PC    = 1'b1;
        bus.w_read  = 1'b1;
        bus.e_MDR   = 1'b1;
      end
      T2: begin
        bus.s_MDR   = 1'b1;
        bus.e_IR    = 1'b1;
      end
      T3: begin
        case (ir_cls)
          CLS_BINARY, CLS_MULDIV: begin
            bus.s_R = onehot(bus.w_IR[22:19]);
            bus.e_Y = 1'b1;
          end
          CLS_UNARY: begin
            bus.s_R    = onehot(bus.w_IR[22:19]);
            bus.e_alu  = 1'b1;
            bus.e_Z    = 1'b1;
            bus.opcode = {1'b0, bus.w_IR[31:27]};
          end
          default: ;
        endcase
      end
      T4: begin
        if (cls_q == CLS_UNARY) begin
          bus.s_Zlow = 1'b1;
          bus.e_R    = onehot(ra_q);
        end else begin
          bus.s_R   = onehot(rc_q);
          bus.e_alu = 1'b1;
          bus.e_Z   = 1'b1;
        end
      end
      T5: begin
        bus.s_Zlow = 1'b1;
        if (cls_q == CLS_MULDIV) bus.e_LO = 1'b1;
        else                     bus.e_R  = onehot(ra_q);
      end
      T6: begin
        bus.s_Zhigh = 1'b1;
        bus.e_HI    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;
  assign bus.illegal = illegal_q;

endmodule
